// File: rtl/pixel_dispatcher_if.sv
// Handshake and camera bus between the pixel dispatcher and the ray generator side.
// The dispatcher connects through the master modport and the consumer through the slave modport.
interface pixel_dispatcher_if #(
    parameter int H_BITS = 9,
    parameter int V_BITS = 8,
    parameter int DATA_W = 16
);
    logic                  frame_start_in;
    logic [3*DATA_W-1:0]   cam_pos_in;
    logic [3*DATA_W-1:0]   cam_forward_in;
    logic                  ready_in;
    logic                  retire_in;
    logic                  valid_out;
    logic [H_BITS-1:0]     hcount_out;
    logic [V_BITS-1:0]     vcount_out;
    logic [3*DATA_W-1:0]   cam_pos_out;
    logic [3*DATA_W-1:0]   cam_forward_out;
    logic                  busy_out;
    logic                  frame_done_out;
    logic                  error_out;

    modport master (
        input  frame_start_in, cam_pos_in, cam_forward_in, ready_in, retire_in,
        output valid_out, hcount_out, vcount_out, cam_pos_out, cam_forward_out,
               busy_out, frame_done_out, error_out
    );

    modport slave (
        output frame_start_in, cam_pos_in, cam_forward_in, ready_in, retire_in,
        input  valid_out, hcount_out, vcount_out, cam_pos_out, cam_forward_out,
               busy_out, frame_done_out, error_out
    );
endinterface

// File: rtl/pixel_dispatcher.sv
// Frame-level pixel scheduler feeding the ray generator.
// Snapshots the camera on frame start, walks the screen in raster order with a
// STEP stride, bounds in-flight pixels with a credit counter and signals frame
// completion once every issued pixel has been retired downstream.
module pixel_dispatcher #(
    parameter int DISPLAY_WIDTH   = 320,
    parameter int DISPLAY_HEIGHT  = 240,
    parameter int H_BITS          = 9,
    parameter int V_BITS          = 8,
    parameter int STEP            = 1,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_W          = 16
) (
    input logic                clk_in,
    input logic                rst_in,
    pixel_dispatcher_if.master bus
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [H_BITS-1:0] H_LAST  = H_BITS'(DISPLAY_WIDTH - STEP);
    localparam logic [V_BITS-1:0] V_LAST  = V_BITS'(DISPLAY_HEIGHT - STEP);
    localparam logic [H_BITS-1:0] H_STEP  = H_BITS'(STEP);
    localparam logic [V_BITS-1:0] V_STEP  = V_BITS'(STEP);
    localparam logic [OUT_W-1:0]  OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state;
    state_t              state_next;
    logic [H_BITS-1:0]   hcount;
    logic [H_BITS-1:0]   hcount_next;
    logic [V_BITS-1:0]   vcount;
    logic [V_BITS-1:0]   vcount_next;
    logic [3*DATA_W-1:0] cam_pos;
    logic [3*DATA_W-1:0] cam_forward;
    logic [OUT_W-1:0]    outstanding;
    logic [OUT_W-1:0]    outstanding_next;
    logic                error;
    logic                error_next;
    logic                valid;
    logic                transfer;
    logic                last_pixel;
    logic                start;
    logic                frame_done;

    // Handshake qualifiers derived only from registered state plus the consumer inputs.
    always_comb begin
        valid      = (state == ISSUE) && (outstanding < OUT_MAX);
        transfer   = valid && bus.ready_in;
        last_pixel = (hcount == H_LAST) && (vcount == V_LAST);
        start      = (state == IDLE) && bus.frame_start_in;
    end

    // Credit counter: issue takes a credit, retire returns one; retire with no credits flags an error.
    always_comb begin
        outstanding_next = outstanding;
        error_next       = error;
        if (transfer && !bus.retire_in) begin
            outstanding_next = outstanding + OUT_W'(1);
        end else if (!transfer && bus.retire_in) begin
            if (outstanding == '0) begin
                error_next = 1'b1;
            end else begin
                outstanding_next = outstanding - OUT_W'(1);
            end
        end
    end

    // Next-state, raster walk and frame completion pulse.
    always_comb begin
        state_next  = state;
        hcount_next = hcount;
        vcount_next = vcount;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.frame_start_in) begin
                    hcount_next = '0;
                    vcount_next = '0;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (transfer) begin
                    if (last_pixel) begin
                        // Park on the last pixel; the raster never runs past it.
                        state_next = DRAIN;
                    end else if (hcount == H_LAST) begin
                        hcount_next = '0;
                        vcount_next = vcount + V_STEP;
                    end else begin
                        hcount_next = hcount + H_STEP;
                    end
                end
            end
            DRAIN: begin
                if (outstanding_next == '0) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control and raster registers, cleared by reset so a mid-frame reset abandons the frame.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            hcount      <= '0;
            vcount      <= '0;
            outstanding <= '0;
            error       <= 1'b0;
        end else begin
            state       <= state_next;
            hcount      <= hcount_next;
            vcount      <= vcount_next;
            outstanding <= outstanding_next;
            error       <= error_next;
        end
    end

    // Camera snapshot, loaded only when a frame is accepted from IDLE.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cam_pos     <= '0;
            cam_forward <= '0;
        end else if (start) begin
            cam_pos     <= bus.cam_pos_in;
            cam_forward <= bus.cam_forward_in;
        end
    end

    assign bus.valid_out       = valid;
    assign bus.hcount_out      = hcount;
    assign bus.vcount_out      = vcount;
    assign bus.cam_pos_out     = cam_pos;
    assign bus.cam_forward_out = cam_forward;
    assign bus.busy_out        = (state != IDLE);
    assign bus.frame_done_out  = frame_done;
    assign bus.error_out       = error;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher: three instances cover the 4x2 full-rate
// raster, a two-credit limit, and an 8x4 raster with stride 2.
module tb_pixel_dispatcher;
    localparam int HB = 4;
    localparam int VB = 4;
    localparam int DW = 16;

    localparam logic [3*DW-1:0] CAM_A_POS = 48'h0001_0002_0003;
    localparam logic [3*DW-1:0] CAM_A_FWD = 48'h0000_0000_4000;
    localparam logic [3*DW-1:0] CAM_B_POS = 48'h0A0A_0B0B_0C0C;
    localparam logic [3*DW-1:0] CAM_B_FWD = 48'h4000_0000_0000;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    pixel_dispatcher_if #(.H_BITS(HB), .V_BITS(VB), .DATA_W(DW)) if_a ();
    pixel_dispatcher_if #(.H_BITS(HB), .V_BITS(VB), .DATA_W(DW)) if_b ();
    pixel_dispatcher_if #(.H_BITS(HB), .V_BITS(VB), .DATA_W(DW)) if_c ();

    pixel_dispatcher #(.DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(2), .H_BITS(HB), .V_BITS(VB),
                       .STEP(1), .MAX_OUTSTANDING(4), .DATA_W(DW))
        dut_a (.clk_in(clk), .rst_in(rst), .bus(if_a));

    pixel_dispatcher #(.DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(2), .H_BITS(HB), .V_BITS(VB),
                       .STEP(1), .MAX_OUTSTANDING(2), .DATA_W(DW))
        dut_b (.clk_in(clk), .rst_in(rst), .bus(if_b));

    pixel_dispatcher #(.DISPLAY_WIDTH(8), .DISPLAY_HEIGHT(4), .H_BITS(HB), .V_BITS(VB),
                       .STEP(2), .MAX_OUTSTANDING(4), .DATA_W(DW))
        dut_c (.clk_in(clk), .rst_in(rst), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected raster orders, written out by hand.
    int exp_h_a [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_v_a [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int exp_h_c [8] = '{0, 2, 4, 6, 0, 2, 4, 6};
    int exp_v_c [8] = '{0, 0, 0, 0, 2, 2, 2, 2};

    int   nx;
    int   nd;
    int   done_at;
    int   nxb;
    logic xf;
    logic pulsed;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        if_a.frame_start_in = 0; if_a.cam_pos_in = '0; if_a.cam_forward_in = '0;
        if_a.ready_in = 0; if_a.retire_in = 0;
        if_b.frame_start_in = 0; if_b.cam_pos_in = '0; if_b.cam_forward_in = '0;
        if_b.ready_in = 0; if_b.retire_in = 0;
        if_c.frame_start_in = 0; if_c.cam_pos_in = '0; if_c.cam_forward_in = '0;
        if_c.ready_in = 0; if_c.retire_in = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Test 1: idle after reset
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t1_a_valid", if_a.valid_out, 0);
        chk("t1_a_busy", if_a.busy_out, 0);
        chk("t1_a_error", if_a.error_out, 0);
        chk("t1_a_done", if_a.frame_done_out, 0);
        chk("t1_a_h", if_a.hcount_out, 0);
        chk("t1_a_v", if_a.vcount_out, 0);
        chk("t1_a_cam", if_a.cam_pos_out, 0);
        chk("t1_a_fwd", if_a.cam_forward_out, 0);
        chk("t1_b_valid", if_b.valid_out, 0);
        chk("t1_b_busy", if_b.busy_out, 0);
        chk("t1_c_valid", if_c.valid_out, 0);
        chk("t1_c_busy", if_c.busy_out, 0);

        // Test 2: full 4x2 frame, retire one cycle after each transfer
        @(posedge clk); #1;
        if_a.cam_pos_in = CAM_A_POS; if_a.cam_forward_in = CAM_A_FWD; if_a.frame_start_in = 1;
        @(posedge clk); #1;
        if_a.frame_start_in = 0; if_a.ready_in = 1;
        if_a.cam_pos_in = CAM_B_POS; if_a.cam_forward_in = CAM_B_FWD;
        nx = 0; nd = 0; done_at = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            xf = if_a.valid_out && if_a.ready_in;
            if (if_a.frame_done_out) begin
                nd++;
                done_at = nx;
            end
            if (xf) begin
                if (nx < 8) begin
                    chk("t2_h", if_a.hcount_out, exp_h_a[nx]);
                    chk("t2_v", if_a.vcount_out, exp_v_a[nx]);
                end
                nx++;
            end
            @(posedge clk); #1;
            if_a.retire_in = xf;
        end
        if_a.retire_in = 0; if_a.ready_in = 0;
        @(negedge clk);
        chk("t2_transfers", nx, 8);
        chk("t2_done_pulses", nd, 1);
        chk("t2_done_after_last", done_at, 8);
        chk("t2_cam_pos", if_a.cam_pos_out, CAM_A_POS);
        chk("t2_cam_fwd", if_a.cam_forward_out, CAM_A_FWD);
        chk("t2_busy", if_a.busy_out, 0);
        chk("t2_error", if_a.error_out, 0);

        // Test 3: two credits, no retire
        @(posedge clk); #1;
        if_b.cam_pos_in = CAM_B_POS; if_b.cam_forward_in = CAM_B_FWD; if_b.frame_start_in = 1;
        @(posedge clk); #1;
        if_b.frame_start_in = 0; if_b.ready_in = 1;
        nxb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if_b.valid_out && if_b.ready_in) nxb++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t3_transfers", nxb, 2);
        chk("t3_valid_stalled", if_b.valid_out, 0);
        chk("t3_busy", if_b.busy_out, 1);
        @(posedge clk); #1;
        if_b.retire_in = 1; if_b.ready_in = 0;
        @(posedge clk); #1;
        if_b.retire_in = 0;
        @(negedge clk);
        chk("t3_valid_after_retire", if_b.valid_out, 1);
        chk("t3_third_h", if_b.hcount_out, 2);
        chk("t3_third_v", if_b.vcount_out, 0);

        // Test 4: stall holds outputs; transfer together with retire keeps credits
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_hold_valid", if_b.valid_out, 1);
            chk("t4_hold_h", if_b.hcount_out, 2);
            chk("t4_hold_v", if_b.vcount_out, 0);
            chk("t4_hold_cam", if_b.cam_pos_out, CAM_B_POS);
            chk("t4_hold_fwd", if_b.cam_forward_out, CAM_B_FWD);
        end
        @(posedge clk); #1;
        if_b.ready_in = 1; if_b.retire_in = 1;
        @(negedge clk);
        chk("t4_xfer_h", if_b.hcount_out, 2);
        @(posedge clk); #1;
        if_b.retire_in = 0;
        @(negedge clk);
        chk("t4_next_valid", if_b.valid_out, 1);
        chk("t4_next_h", if_b.hcount_out, 3);
        chk("t4_next_v", if_b.vcount_out, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_full_again", if_b.valid_out, 0);
        chk("t4_error", if_b.error_out, 0);
        if_b.ready_in = 0;

        // Test 5: 8x4 frame with stride 2 and an ignored mid-frame start
        @(posedge clk); #1;
        if_c.cam_pos_in = CAM_A_POS; if_c.cam_forward_in = CAM_A_FWD; if_c.frame_start_in = 1;
        @(posedge clk); #1;
        if_c.frame_start_in = 0; if_c.ready_in = 1;
        nx = 0; nd = 0; done_at = -1; pulsed = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            xf = if_c.valid_out && if_c.ready_in;
            if (if_c.frame_done_out) begin
                nd++;
                done_at = nx;
            end
            if (xf) begin
                if (nx < 8) begin
                    chk("t5_h", if_c.hcount_out, exp_h_c[nx]);
                    chk("t5_v", if_c.vcount_out, exp_v_c[nx]);
                end
                nx++;
            end
            @(posedge clk); #1;
            if_c.retire_in = xf;
            if_c.frame_start_in = 0;
            if (nx == 3 && !pulsed) begin
                pulsed = 1;
                if_c.frame_start_in = 1;
                if_c.cam_pos_in = CAM_B_POS; if_c.cam_forward_in = CAM_B_FWD;
            end
        end
        if_c.retire_in = 0; if_c.ready_in = 0; if_c.frame_start_in = 0;
        @(negedge clk);
        chk("t5_transfers", nx, 8);
        chk("t5_done_pulses", nd, 1);
        chk("t5_done_after_last", done_at, 8);
        chk("t5_cam_pos_kept", if_c.cam_pos_out, CAM_A_POS);
        chk("t5_cam_fwd_kept", if_c.cam_forward_out, CAM_A_FWD);
        chk("t5_busy", if_c.busy_out, 0);

        // Test 6: spurious retire is sticky; reset mid-frame restarts cleanly
        @(posedge clk); #1;
        if_a.retire_in = 1;
        @(posedge clk); #1;
        if_a.retire_in = 0;
        @(negedge clk);
        chk("t6_error_set", if_a.error_out, 1);
        chk("t6_busy_idle", if_a.busy_out, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_error_sticky", if_a.error_out, 1);
        @(posedge clk); #1;
        if_a.cam_pos_in = CAM_B_POS; if_a.cam_forward_in = CAM_B_FWD; if_a.frame_start_in = 1;
        @(posedge clk); #1;
        if_a.frame_start_in = 0; if_a.ready_in = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_mid_h", if_a.hcount_out, 2);
        chk("t6_mid_busy", if_a.busy_out, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; if_a.ready_in = 0;
        @(negedge clk);
        chk("t6_rst_valid", if_a.valid_out, 0);
        chk("t6_rst_busy", if_a.busy_out, 0);
        chk("t6_rst_error", if_a.error_out, 0);
        chk("t6_rst_h", if_a.hcount_out, 0);
        chk("t6_rst_v", if_a.vcount_out, 0);
        chk("t6_rst_cam", if_a.cam_pos_out, 0);
        chk("t6_rst_fwd", if_a.cam_forward_out, 0);
        chk("t6_rst_b_busy", if_b.busy_out, 0);
        @(posedge clk); #1;
        if_a.cam_pos_in = CAM_A_POS; if_a.cam_forward_in = CAM_A_FWD; if_a.frame_start_in = 1;
        @(posedge clk); #1;
        if_a.frame_start_in = 0; if_a.ready_in = 1;
        @(negedge clk);
        chk("t6_restart_valid", if_a.valid_out, 1);
        chk("t6_restart_h", if_a.hcount_out, 0);
        chk("t6_restart_v", if_a.vcount_out, 0);
        chk("t6_restart_cam", if_a.cam_pos_out, CAM_A_POS);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_restart_second_h", if_a.hcount_out, 1);
        if_a.ready_in = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
